mult_arbiter: RTL and testbench

Shares one pipelined array_multiplier instance between NUM_REQ requesters. Each requester has a valid/ready request channel. A round-robin arbiter grants one operand pair per cycle, registers it onto the multiplier input and tags it with the requester ID. Products return through a credit-guarded result FIFO to a single valid/ready response channel, so the fixed-latency, no-backpressure multiplier can never overflow.

---
 rtl/mult_arbiter_pkg.sv | 11 +
 rtl/mult_arbiter_if.sv | 29 ++
 rtl/mult_arbiter_rr_arbiter.sv | 35 +++
 rtl/mult_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mult_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared helpers for the multiplier-sharing arbiter.
// Latency: none; compile-time only.
// Backpressure: not applicable.
package mult_arb_pkg;

  // Requester index width; never zero so single-requester builds still have an id bit.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response channels between requesters and the shared multiplier arbiter.
// Latency: wires only.
// Backpressure: valid/ready on both channels; req_ready is one-hot or zero.
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int DATAWIDTH = 4,
  parameter int NUM_REQ   = 4,
  parameter int IDW       = calc_idw(NUM_REQ)
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [IDW-1:0]               rsp_id;
  logic [2*DATAWIDTH-1:0]       rsp_z;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin grant: first set req bit scanning upward from ptr with wrap-around.
// Latency: purely combinational.
// Backpressure: en low forces no grant.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = calc_idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !grant_valid && req[idx]) begin
        grant_valid       = 1'b1;
        grant_idx         = IDW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one fixed-latency multiplier between NUM_REQ requesters; optional MULT_ARB_STATS_EN adds counters.
// Latency: handshake T -> mul_i_valid T+1 -> FIFO push T+1+MULT_LATENCY -> rsp_valid T+2+MULT_LATENCY.
// Backpressure: issue only while fifo_count + inflight < FIFO_DEPTH, so the multiplier never overflows the FIFO.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int DATAWIDTH    = 4,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_arbiter_if.slave          bus,
  output logic                   mul_i_valid,
  output logic [DATAWIDTH-1:0]   mul_a,
  output logic [DATAWIDTH-1:0]   mul_b,
  input  logic                   mul_o_valid,
  input  logic [2*DATAWIDTH-1:0] mul_z,
  output logic                   err_tag
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int IDW = calc_idw(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [IDW-1:0]         id;
    logic [2*DATAWIDTH-1:0] z;
  } rsp_entry_t;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] issue_id;
  logic [IDW-1:0] grant_idx;
  logic           grant_valid;
  logic           issue_ok;
  int             inflight;

  tag_t           tag_sr [MULT_LATENCY];
  tag_t           tag_out;

  rsp_entry_t     mem [FIFO_DEPTH];
  rsp_entry_t     head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           push;
  logic           pop;

  // Credit is sampled from registered state only, so a pop frees a slot one cycle later.
  always_comb begin
    inflight = int'(mul_i_valid);
    for (int i = 0; i < MULT_LATENCY; i++) begin
      inflight = inflight + int'(tag_sr[i].valid);
    end
    issue_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req          (bus.req_valid),
    .ptr          (ptr),
    .en           (issue_ok),
    .grant_onehot (bus.req_ready),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_i_valid <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      issue_id    <= '0;
    end else if (grant_valid) begin
      mul_i_valid <= 1'b1;
      mul_a       <= bus.req_a[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
      mul_b       <= bus.req_b[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
      issue_id    <= grant_idx;
    end else begin
      mul_i_valid <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      issue_id    <= '0;
    end
  end

  // Tag travels alongside the operands; its tail lines up with mul_o_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      tag_sr[0] <= '{valid: mul_i_valid, id: issue_id};
      for (int i = 1; i < MULT_LATENCY; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign tag_out = tag_sr[MULT_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_tag <= 1'b0;
    end else if (mul_o_valid != tag_out.valid) begin
      err_tag <= 1'b1;
    end
  end

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = bus.rsp_valid && bus.rsp_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = mul_o_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{id: tag_out.id, z: mul_z};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.rsp_valid = (fifo_count != '0);
  assign bus.rsp_id    = bus.rsp_valid ? head.id : '0;
  assign bus.rsp_z     = bus.rsp_valid ? head.z  : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mul_o_valid && fifo_full && !pop))
        else $error("mult_arbiter: multiplier result arrived with the result FIFO full");
    end
  end
`endif

`ifdef MULT_ARB_STATS_EN
  // Both counters saturate rather than wrap so long runs never read as small.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_valid && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 1'b1;
      end
      if ((|bus.req_valid) && !issue_ok && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: multiplier stub, random and directed stimulus, queue-based reference model.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int L  = 3;
  localparam int D  = 4;

  typedef struct {
    int id;
    int z;
    int rdy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            spur = 1'b0;
  logic            mul_i_valid;
  logic [DW-1:0]   mul_a;
  logic [DW-1:0]   mul_b;
  logic            mul_o_valid;
  logic [2*DW-1:0] mul_z;
  logic            err_tag;
`ifdef MULT_ARB_STATS_EN
  logic [31:0]     stat_issued;
  logic [31:0]     stat_stall;
`endif

  mult_arbiter_if #(.DATAWIDTH(DW), .NUM_REQ(NR)) bus ();

  mult_arbiter #(
    .DATAWIDTH    (DW),
    .NUM_REQ      (NR),
    .MULT_LATENCY (L),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mul_i_valid (mul_i_valid),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_o_valid (mul_o_valid),
    .mul_z       (mul_z),
    .err_tag     (err_tag)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Fixed-latency multiplier stub sharing the arbiter's reset.
  logic            mp_v [L];
  logic [2*DW-1:0] mp_z [L];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        mp_v[i] <= 1'b0;
        mp_z[i] <= '0;
      end
    end else begin
      mp_v[0] <= mul_i_valid;
      mp_z[0] <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
      for (int i = 1; i < L; i++) begin
        mp_v[i] <= mp_v[i-1];
        mp_z[i] <= mp_z[i-1];
      end
    end
  end

  assign mul_o_valid = mp_v[L-1] | spur;
  assign mul_z       = mp_z[L-1];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ptr_m = 0;
  int outstanding = 0;
  int issued_m = 0;
  int stall_m = 0;
  int dut_grants = 0;
  int lat;
  bit err_m = 1'b0;
  bit seen_valid;
  exp_t exp_q[$];
  int grant_log[$];
  logic [DW-1:0] a_v [NR];
  logic [DW-1:0] b_v [NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic clear_model();
    exp_q.delete();
    ptr_m       = 0;
    outstanding = 0;
    err_m       = 1'b0;
    issued_m    = 0;
    stall_m     = 0;
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst           = 1'b1;
    spur          = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    clear_model();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mul_i_valid", mul_i_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_z", bus.rsp_z, 0);
    chk("rst_err_tag", err_tag, 0);
`ifdef MULT_ARB_STATS_EN
    chk("rst_stat_issued", stat_issued, 0);
    chk("rst_stat_stall", stat_stall, 0);
`endif
  endtask

  // One clock: drive inputs after negedge, predict grant and response, then update the model.
  task automatic drive_cycle(input logic [NR-1:0] v, input bit rdy, input bit rnd, input bit chk_rsp);
    int g;
    int idx;
    bit exp_v;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (rnd) begin
        a_v[i] = DW'($urandom_range(0, (1 << DW) - 1));
        b_v[i] = DW'($urandom_range(0, (1 << DW) - 1));
      end
      bus.req_a[i*DW +: DW] = a_v[i];
      bus.req_b[i*DW +: DW] = b_v[i];
    end
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    #1;
    g       = -1;
    exp_rdy = '0;
    if (outstanding < D) begin
      for (int k = 0; k < NR; k++) begin
        idx = (ptr_m + k) % NR;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    else if (v != '0) stall_m++;
    chk("req_ready", bus.req_ready, exp_rdy);
    if (bus.req_ready != '0) begin
      dut_grants++;
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) grant_log.push_back(i);
    end
    seen_valid = bus.rsp_valid;
    exp_v = (exp_q.size() != 0) && (exp_q[0].rdy <= cyc);
    if (chk_rsp) begin
      chk("rsp_valid", bus.rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_id", bus.rsp_id, exp_q[0].id);
        chk("rsp_z", bus.rsp_z, exp_q[0].z);
      end
    end
    chk("err_tag", err_tag, err_m);
    if (exp_v && rdy) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (g >= 0) begin
      exp_q.push_back('{g, int'(a_v[g]) * int'(b_v[g]), cyc + L + 2});
      ptr_m = (g + 1) % NR;
      outstanding++;
      issued_m++;
    end
    cyc++;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    reset_pulse(3);

    // Single request from requester 2: 7*9 appears five cycles after the handshake.
    a_v[2] = 4'd7;
    b_v[2] = 4'd9;
    drive_cycle(4'b0100, 1'b1, 1'b0, 1'b1);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      drive_cycle('0, 1'b1, 1'b0, 1'b1);
      if (seen_valid && lat < 0) begin
        lat = k;
        chk("single_id", bus.rsp_id, 2);
        chk("single_z", bus.rsp_z, 63);
      end
    end
    chk("single_latency", lat, 5);

    // All requesters active: grants rotate 0,1,2,3 from a reset pointer.
    reset_pulse(1);
    grant_log.delete();
    repeat (40) drive_cycle('1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) chk("rr_order", grant_log[k], k % NR);
    repeat (15) drive_cycle('0, 1'b1, 1'b1, 1'b1);

    // Response channel stalled: exactly FIFO_DEPTH grants, then resume.
    dut_grants = 0;
    repeat (20) drive_cycle('1, 1'b0, 1'b1, 1'b1);
    chk("bp_grants", dut_grants, D);
    repeat (30) drive_cycle('1, 1'b1, 1'b1, 1'b1);

    // Saturated stream with rsp_ready toggling every cycle.
    for (int k = 0; k < 60; k++) drive_cycle('1, k[0], 1'b1, 1'b1);

    // Random request patterns and random response backpressure.
    for (int k = 0; k < 400; k++) begin
      drive_cycle(NR'($urandom_range(0, (1 << NR) - 1)), ($urandom_range(0, 3) != 0), 1'b1, 1'b1);
    end
    repeat (20) drive_cycle('0, 1'b1, 1'b1, 1'b1);
`ifdef MULT_ARB_STATS_EN
    chk("stat_issued", stat_issued, issued_m);
    chk("stat_stall", stat_stall, stall_m);
`endif

    // Reset with three products in flight; none of them may surface afterwards.
    repeat (3) drive_cycle('1, 1'b1, 1'b1, 1'b1);
    reset_pulse(1);
    repeat (12) drive_cycle('0, 1'b1, 1'b1, 1'b1);

    // Spurious multiplier valid sets the sticky tag error until reset.
    drive_cycle('0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur  = 1'b0;
    err_m = 1'b1;
    repeat (5) drive_cycle('0, 1'b0, 1'b1, 1'b0);
    reset_pulse(1);
    repeat (3) drive_cycle('0, 1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
